// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB widths and phase encoding
package apb_pkg;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;
  localparam int APB_SW = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_phase_e;

endpackage

// File: rtl/ram_array.sv
// rtl/ram_array.sv - word array with byte write enables and a registered read port
module ram_array #(
  parameter int DEPTH     = 1024,
  parameter int IDX_W     = 10,
  parameter int DW        = 32,
  parameter int SW        = 4,
  parameter     INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [DW-1:0]    i_wdata,
  input  logic [SW-1:0]    i_wstrb,
  input  logic             i_re,
  input  logic             i_rclr,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [DW-1:0]    o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < SW; b++) begin
        if (i_wstrb[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end else if (i_rclr) begin
      r_rdata <= '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/apb_ram.sv
// rtl/apb_ram.sv - zero-wait-state APB4 slave RAM
module apb_ram
  import apb_pkg::*;
#(
  parameter logic [APB_AW-1:0] RAM_SIZE  = 32'h0010_0000,
  parameter                    INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  output logic              pready,
  input  logic [APB_AW-1:0] paddr,
  input  logic              pwrite,
  input  logic [APB_DW-1:0] pwdata,
  input  logic [APB_SW-1:0] pwstrb,
  output logic [APB_DW-1:0] prdata,
  output logic              pslverr
);

  localparam int ADDR_W = $clog2(RAM_SIZE);
  localparam int IDX_W  = (ADDR_W > 2) ? ADDR_W - 2 : 1;
  localparam int DEPTH  = int'(RAM_SIZE >> 2);

  apb_phase_e        w_phase;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;
  logic              w_we;
  logic              w_re;
  logic              w_rclr;

  logic [IDX_W-1:0]  r_idx;
  logic              r_write;
  logic [APB_DW-1:0] r_wdata;
  logic [APB_SW-1:0] r_wstrb;
  logic              r_in_range;
  logic              r_pready;
  logic              r_pslverr;

  // An access phase is only honoured after our own setup phase raised pready.
  always_comb begin
    w_phase = IDLE;
    if (psel && !penable)                 w_phase = SETUP;
    else if (psel && penable && r_pready) w_phase = ACCESS;
  end

  assign w_in_range = (paddr < RAM_SIZE);
  assign w_idx      = paddr[IDX_W+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_in_range <= 1'b0;
      r_pready   <= 1'b0;
      r_pslverr  <= 1'b0;
    end else if (w_phase == SETUP) begin
      r_idx      <= w_idx;
      r_write    <= pwrite;
      r_wdata    <= pwdata;
      r_wstrb    <= pwstrb;
      r_in_range <= w_in_range;
      r_pready   <= 1'b1;
      r_pslverr  <= !w_in_range;
    end else begin
      r_pready   <= 1'b0;
      r_pslverr  <= 1'b0;
    end
  end

  assign w_we   = (w_phase == ACCESS) && r_write && r_in_range;
  assign w_re   = (w_phase == SETUP) && !pwrite && w_in_range;
  assign w_rclr = (w_phase == SETUP) && !w_re;

  ram_array #(
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W),
    .DW        (APB_DW),
    .SW        (APB_SW),
    .INIT_FILE (INIT_FILE)
  ) u_ram_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (r_idx),
    .i_wdata (r_wdata),
    .i_wstrb (r_wstrb),
    .i_re    (w_re),
    .i_rclr  (w_rclr),
    .i_raddr (w_idx),
    .o_rdata (prdata)
  );

  assign pready  = r_pready;
  assign pslverr = r_pslverr;

endmodule

// File: tb/tb_apb_ram.sv
// tb/tb_apb_ram.sv - scoreboard bench for apb_ram
module tb_apb_ram;

  localparam logic [31:0] RAM_SIZE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel;
  logic        penable;
  logic        pready;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pwstrb;
  logic [31:0] prdata;
  logic        pslverr;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_push   = 0;
  int   n_resp   = 0;
  logic prev_pready = 1'b0;

  apb_ram #(
    .RAM_SIZE  (RAM_SIZE),
    .INIT_FILE ("")
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .psel    (psel),
    .penable (penable),
    .pready  (pready),
    .paddr   (paddr),
    .pwrite  (pwrite),
    .pwdata  (pwdata),
    .pwstrb  (pwstrb),
    .prdata  (prdata),
    .pslverr (pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Called at #1 after an edge; leaves the bus idle at #1 after the access edge.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [31:0] exp_rdata, input logic exp_err);
    exp_t e;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    pwstrb  = strb;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.tag   = n_push;
    exp_q.push_back(e);
    n_push++;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && pready === 1'b1) begin
      exp_t e;
      n_resp++;
      chk("pready_one_cycle", {31'd0, prev_pready}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pready", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("pslverr[%0d]", e.tag), {31'd0, pslverr}, {31'd0, e.err});
        chk($sformatf("prdata[%0d]", e.tag), prdata, e.rdata);
      end
    end
    prev_pready = pready;
  end

  initial begin
    rst_n   = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pwstrb  = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_pready", {31'd0, pready}, 32'd0);
    chk("reset_pslverr", {31'd0, pslverr}, 32'd0);
    chk("reset_prdata", prdata, 32'd0);
    @(posedge clk); #1;

    // full write / read
    xfer(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    idle(1);
    xfer(1'b0, 32'h100, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
    idle(1);

    // partial and empty strobes
    xfer(1'b1, 32'h100, 32'h11223344, 4'b0101, 32'h0, 1'b0);
    xfer(1'b0, 32'h100, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);
    xfer(1'b1, 32'h100, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0);
    xfer(1'b0, 32'h102, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);
    idle(2);

    // out of range; RAM_SIZE aliases word 0 in the index bits
    xfer(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
    xfer(1'b1, RAM_SIZE, 32'h12345678, 4'hF, 32'h0, 1'b1);
    xfer(1'b0, RAM_SIZE + 32'd4, 32'h0, 4'hF, 32'h0, 1'b1);
    xfer(1'b0, 32'h0, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0);
    xfer(1'b1, RAM_SIZE - 32'd4, 32'h0F1E2D3C, 4'hF, 32'h0, 1'b0);
    xfer(1'b0, RAM_SIZE - 32'd4, 32'h0, 4'hF, 32'h0F1E2D3C, 1'b0);
    xfer(1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 32'h0, 1'b1);
    idle(1);

    // back-to-back write then read of the same word
    xfer(1'b1, 32'h104, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0);
    xfer(1'b0, 32'h104, 32'h0, 4'hF, 32'hA5A5A5A5, 1'b0);
    xfer(1'b0, 32'h100, 32'h0, 4'hF, 32'hDE22BE44, 1'b0);
    idle(1);

    // penable without setup must be ignored
    psel    = 1'b1;
    penable = 1'b1;
    pwrite  = 1'b1;
    paddr   = 32'h100;
    pwdata  = 32'h0;
    pwstrb  = 4'hF;
    @(negedge clk);
    chk("no_setup_pready_a", {31'd0, pready}, 32'd0);
    @(negedge clk);
    chk("no_setup_pready_b", {31'd0, pready}, 32'd0);
    @(posedge clk); #1;
    psel    = 1'b0;
    penable = 1'b0;
    xfer(1'b0, 32'h100, 32'h0, 4'hF, 32'hDE22BE44, 1'b0);
    idle(1);

    // reset during an access phase drops the write
    xfer(1'b1, 32'h200, 32'h0BADF00D, 4'hF, 32'h0, 1'b0);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h200;
    pwdata  = 32'h55555555;
    pwstrb  = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("abort_pready", {31'd0, pready}, 32'd0);
    chk("abort_pslverr", {31'd0, pslverr}, 32'd0);
    @(posedge clk); #1;
    psel    = 1'b0;
    penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    xfer(1'b0, 32'h200, 32'h0, 4'hF, 32'h0BADF00D, 1'b0);
    idle(3);

    chk("queue_empty", exp_q.size(), 32'd0);
    chk("resp_count", n_resp, n_push);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
